// File: rtl/elc3_mem_pkg.sv
// Shared types and defaults for the eLC-3 memory bus controller.
package elc3_mem_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam logic [DATA_W-1:0] MMIO_ADDR_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Datapath-side request/response bus between the eLC-3 datapath and the memory controller.
interface mem_bus_ctrl_if;
  import elc3_mem_pkg::*;

  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] Data_In;
  logic              MIO_EN;
  logic              R_W;
  logic [DATA_W-1:0] Data_Out;
  logic              Ready;

  modport master (output Address, Data_In, MIO_EN, R_W, input Data_Out, Ready);
  modport slave  (input Address, Data_In, MIO_EN, R_W, output Data_Out, Ready);
endinterface

// File: rtl/mem_bus_ctrl_mmio_regs.sv
// Read-data return register (switch or SRAM source) and hex-display register.
module mmio_regs
  import elc3_mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sw_ld,
  input  logic              i_sram_ld,
  input  logic              i_hex_ld,
  input  logic [DATA_W-1:0] i_sw,
  input  logic [DATA_W-1:0] i_sram_dq,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DATA_W-1:0] o_hex
);

  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_hex;

  // Read data holds until the next read capture; writes never touch it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
      r_hex   <= '0;
    end else begin
      if (i_sw_ld)        r_rdata <= i_sw;
      else if (i_sram_ld) r_rdata <= i_sram_dq;
      if (i_hex_ld)       r_hex   <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;
  assign o_hex   = r_hex;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side stage of the eLC-3: multi-cycle async-SRAM access or MMIO at MMIO_ADDR,
// returning read data and a one-cycle Ready strobe to the datapath.
module mem_bus_ctrl
  import elc3_mem_pkg::*;
#(
  parameter int unsigned       SRAM_AW     = 20,
  parameter int unsigned       WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  mem_bus_ctrl_if.slave      bus,
  input  logic [DATA_W-1:0]  SW,
  output logic [DATA_W-1:0]  HEX_Data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0]  SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_rw;
  logic               r_mmio;
  logic               r_ready;
  logic               r_ce_n, r_oe_n, r_we_n, r_be_n, r_dq_oe;

  logic w_rw, w_mmio, w_hit, w_last, w_accept;
  logic w_sw_ld, w_sram_ld, w_hex_ld;

  assign w_accept = (r_state == IDLE) && bus.MIO_EN;
  assign w_hit    = (bus.Address == MMIO_ADDR);
  assign w_last   = (r_cnt == CNT_W'(WAIT_CYCLES - 1));

  // Next-state decode; w_rw/w_mmio are the attributes of the transfer as of next cycle.
  always_comb begin
    w_next    = r_state;
    w_rw      = r_rw;
    w_mmio    = r_mmio;
    w_sw_ld   = 1'b0;
    w_sram_ld = 1'b0;
    w_hex_ld  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MIO_EN) begin
          w_rw   = bus.R_W;
          w_mmio = w_hit;
          if (w_hit) begin
            w_next   = DONE;
            w_sw_ld  = !bus.R_W;
            w_hex_ld = bus.R_W;
          end else begin
            w_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (w_last) begin
          w_next    = DONE;
          w_sram_ld = !r_rw;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SRAM strobes are registered from the next-state decode so they are glitch-free.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sram_addr <= '0;
      r_wdata     <= '0;
      r_rw        <= 1'b0;
      r_mmio      <= 1'b0;
      r_ready     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_be_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rw    <= w_rw;
      r_mmio  <= w_mmio;
      if (w_accept) begin
        r_cnt   <= '0;
        r_wdata <= bus.Data_In;
        if (!w_hit) r_sram_addr <= SRAM_AW'(bus.Address);
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_ready <= (w_next == DONE);
      r_ce_n  <= (w_next != ACCESS);
      r_be_n  <= (w_next != ACCESS);
      r_oe_n  <= !((w_next == ACCESS) && !w_rw);
      r_we_n  <= !((w_next == ACCESS) && w_rw);
      // Write data stays on DQ through DONE for SRAM hold time.
      r_dq_oe <= w_rw && !w_mmio && ((w_next == ACCESS) || (w_next == DONE));
    end
  end

  mmio_regs u_mmio_regs (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_sw_ld   (w_sw_ld),
    .i_sram_ld (w_sram_ld),
    .i_hex_ld  (w_hex_ld),
    .i_sw      (SW),
    .i_sram_dq (SRAM_DQ),
    .i_wdata   (bus.Data_In),
    .o_rdata   (bus.Data_Out),
    .o_hex     (HEX_Data)
  );

  assign bus.Ready = r_ready;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_UB_N = r_be_n;
  assign SRAM_LB_N = r_be_n;
  assign SRAM_DQ   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: default build plus a WAIT_CYCLES=1 build, each with an SRAM model.
module tb_mem_bus_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  logic [15:0] SW, HEX_Data, HEX2_Data;
  logic [19:0] SRAM_ADDR, SRAM2_ADDR;
  wire  [15:0] SRAM_DQ, SRAM2_DQ;
  logic ce_n, oe_n, we_n, ub_n, lb_n;
  logic ce2_n, oe2_n, we2_n, ub2_n, lb2_n;

  int total = 0;
  int bad = 0;
  int contention = 0;

  mem_bus_ctrl_if bus ();
  mem_bus_ctrl_if bus2 ();

  always #5 Clk = ~Clk;

  mem_bus_ctrl #(.SRAM_AW(20), .WAIT_CYCLES(2), .MMIO_ADDR(16'hFFFF)) u_dut (
    .Clk(Clk), .Reset(Reset), .bus(bus), .SW(SW), .HEX_Data(HEX_Data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  mem_bus_ctrl #(.SRAM_AW(20), .WAIT_CYCLES(1), .MMIO_ADDR(16'hFFFF)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .bus(bus2), .SW(SW), .HEX_Data(HEX2_Data),
    .SRAM_ADDR(SRAM2_ADDR), .SRAM_DQ(SRAM2_DQ), .SRAM_CE_N(ce2_n), .SRAM_OE_N(oe2_n),
    .SRAM_WE_N(we2_n), .SRAM_UB_N(ub2_n), .SRAM_LB_N(lb2_n)
  );

  // SRAM model for the default build; second build returns ~address on reads.
  logic [15:0] mem [0:65535];
  assign SRAM_DQ  = (!ce_n && !oe_n) ? mem[SRAM_ADDR[15:0]] : 16'hzzzz;
  assign SRAM2_DQ = (!ce2_n && !oe2_n) ? ~SRAM2_ADDR[15:0] : 16'hzzzz;

  always @(posedge Clk) begin
    if (!ce_n && !we_n) mem[SRAM_ADDR[15:0]] <= SRAM_DQ;
    if (!oe_n && (!we_n || u_dut.r_dq_oe)) contention++;
    if (!oe2_n && (!we2_n || u_dut2.r_dq_oe)) contention++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Runs one access on the default build, holding MIO_EN until Ready.
  task automatic do_access(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                           output int edges, output int we_cyc, output int ce_cyc);
    bus.Address = addr; bus.Data_In = data; bus.R_W = rw; bus.MIO_EN = 1'b1;
    edges = -1; we_cyc = 0; ce_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!ce_n) ce_cyc++;
      if (!we_n) we_cyc++;
      if (bus.Ready) begin
        edges = i;
        break;
      end
    end
    bus.MIO_EN = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    total++; if (bus.Ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.Ready); end
    total++; if (bus.Data_Out !== 16'h0) begin bad++; $display("FAIL reset_dout: got %h want 0000", bus.Data_Out); end
    total++; if (HEX_Data !== 16'h0) begin bad++; $display("FAIL reset_hex: got %h want 0000", HEX_Data); end
    total++; if (SRAM_ADDR !== 20'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000", SRAM_ADDR); end
    total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin bad++;
      $display("FAIL reset_ctl: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
    total++; if (u_dut.r_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq: got %b want 0", u_dut.r_dq_oe); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_sram_write_read();
    int e, w, c;
    do_access(1'b1, 16'h3000, 16'hBEEF, e, w, c);
    total++; if (e !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", e); end
    total++; if (w !== 2) begin bad++; $display("FAIL wr_we_cycles: got %0d want 2", w); end
    tick();
    total++; if (bus.Ready !== 1'b0) begin bad++; $display("FAIL wr_ready_width: got %b want 0", bus.Ready); end
    total++; if (mem[16'h3000] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem: got %h want beef", mem[16'h3000]); end
    do_access(1'b0, 16'h3000, 16'h0000, e, w, c);
    total++; if (e !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", e); end
    total++; if (bus.Data_Out !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", bus.Data_Out); end
    total++; if (w !== 0) begin bad++; $display("FAIL rd_we_cycles: got %0d want 0", w); end
    tick();
  endtask

  task automatic test_mmio();
    int e, w, c;
    SW = 16'h1234;
    do_access(1'b0, 16'hFFFF, 16'h0000, e, w, c);
    total++; if (e !== 1) begin bad++; $display("FAIL mmio_rd_latency: got %0d want 1", e); end
    total++; if (bus.Data_Out !== 16'h1234) begin bad++; $display("FAIL mmio_rd_data: got %h want 1234", bus.Data_Out); end
    total++; if (c !== 0) begin bad++; $display("FAIL mmio_rd_ce: got %0d want 0", c); end
    tick();
    do_access(1'b1, 16'hFFFF, 16'h00A5, e, w, c);
    total++; if (e !== 1) begin bad++; $display("FAIL mmio_wr_latency: got %0d want 1", e); end
    total++; if (HEX_Data !== 16'h00A5) begin bad++; $display("FAIL mmio_hex: got %h want 00a5", HEX_Data); end
    total++; if (c !== 0 || w !== 0) begin bad++; $display("FAIL mmio_wr_sram: got ce=%0d we=%0d want 0 0", c, w); end
    total++; if (mem[16'hFFFF] !== 16'h7777) begin bad++; $display("FAIL mmio_mem: got %h want 7777", mem[16'hFFFF]); end
    total++; if (bus.Data_Out !== 16'h1234) begin bad++; $display("FAIL mmio_dout_hold: got %h want 1234", bus.Data_Out); end
    tick();
  endtask

  task automatic test_reset_mid();
    int rdy, e, w, c;
    rdy = 0;
    bus.Address = 16'h5000; bus.Data_In = 16'h1357; bus.R_W = 1'b1; bus.MIO_EN = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    #1;
    total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin bad++;
      $display("FAIL rstmid_ctl: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
    total++; if (u_dut.r_dq_oe !== 1'b0) begin bad++; $display("FAIL rstmid_dq: got %b want 0", u_dut.r_dq_oe); end
    bus.MIO_EN = 1'b0;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Ready) rdy++;
    end
    total++; if (rdy !== 0) begin bad++; $display("FAIL rstmid_noready: got %0d want 0", rdy); end
    do_access(1'b0, 16'h0001, 16'h0000, e, w, c);
    total++; if (e !== 3 || bus.Data_Out !== 16'h1111) begin bad++;
      $display("FAIL rstmid_idle: got edges=%0d data=%h want 3 1111", e, bus.Data_Out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    int idx [2];
    logic [15:0] dat [2];
    n = 0; idx[0] = -1; idx[1] = -1; dat[0] = '0; dat[1] = '0;
    bus.Address = 16'h0001; bus.R_W = 1'b0; bus.MIO_EN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.Ready) begin
        if (n < 2) begin idx[n] = i; dat[n] = bus.Data_Out; end
        n++;
        bus.Address = 16'h0002;
        if (n == 2) bus.MIO_EN = 1'b0;
      end
    end
    bus.MIO_EN = 1'b0;
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", n); end
    total++; if (idx[0] !== 3 || idx[1] !== 7) begin bad++;
      $display("FAIL b2b_timing: got %0d,%0d want 3,7", idx[0], idx[1]); end
    total++; if (dat[0] !== 16'h1111 || dat[1] !== 16'h2222) begin bad++;
      $display("FAIL b2b_data: got %h,%h want 1111,2222", dat[0], dat[1]); end
  endtask

  task automatic test_glitch();
    int n, e, badaddr, wecyc;
    n = 0; e = -1; badaddr = 0; wecyc = 0;
    bus.Address = 16'h0002; bus.R_W = 1'b0; bus.MIO_EN = 1'b1;
    tick();
    bus.MIO_EN = 1'b0; bus.Address = 16'h4000; bus.R_W = 1'b1;
    if (!ce_n && SRAM_ADDR !== 20'h00002) badaddr++;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (!ce_n && SRAM_ADDR !== 20'h00002) badaddr++;
      if (!we_n) wecyc++;
      if (bus.Ready) begin n++; e = i; end
    end
    total++; if (n !== 1 || e !== 3) begin bad++; $display("FAIL glitch_ready: got n=%0d at %0d want 1 at 3", n, e); end
    total++; if (badaddr !== 0 || wecyc !== 0) begin bad++;
      $display("FAIL glitch_addr: got badaddr=%0d we=%0d want 0 0", badaddr, wecyc); end
    total++; if (bus.Data_Out !== 16'h2222) begin bad++; $display("FAIL glitch_data: got %h want 2222", bus.Data_Out); end
  endtask

  task automatic test_wait1();
    int e, w;
    e = -1; w = 0;
    bus2.Address = 16'h0ABC; bus2.Data_In = 16'h0; bus2.R_W = 1'b0; bus2.MIO_EN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus2.Ready) begin e = i; break; end
    end
    bus2.MIO_EN = 1'b0;
    total++; if (e !== 2) begin bad++; $display("FAIL w1_rd_latency: got %0d want 2", e); end
    total++; if (bus2.Data_Out !== 16'hF543) begin bad++; $display("FAIL w1_rd_data: got %h want f543", bus2.Data_Out); end
    tick();
    e = -1;
    bus2.Address = 16'h0123; bus2.Data_In = 16'h5555; bus2.R_W = 1'b1; bus2.MIO_EN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!we2_n) w++;
      if (bus2.Ready) begin e = i; break; end
    end
    bus2.MIO_EN = 1'b0;
    total++; if (e !== 2 || w !== 1) begin bad++; $display("FAIL w1_wr: got edges=%0d we=%0d want 2 1", e, w); end
    tick();
    total++; if (contention !== 0) begin bad++; $display("FAIL contention: got %0d want 0", contention); end
  endtask

  initial begin
    Reset = 1'b1;
    SW = 16'h0;
    bus.Address = '0; bus.Data_In = '0; bus.R_W = 1'b0; bus.MIO_EN = 1'b0;
    bus2.Address = '0; bus2.Data_In = '0; bus2.R_W = 1'b0; bus2.MIO_EN = 1'b0;
    mem[16'h0001] = 16'h1111;
    mem[16'h0002] = 16'h2222;
    mem[16'h3000] = 16'h0000;
    mem[16'h4000] = 16'hDEAD;
    mem[16'hFFFF] = 16'h7777;
    test_reset();
    test_sram_write_read();
    test_mmio();
    test_reset_mid();
    test_back_to_back();
    test_glitch();
    test_wait1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
